// File: rtl/demux_sel_seq.sv
// Request sequencer feeding a 1:4 demux: one-hot select held for HOLD_CYCLES, then GUARD_CYCLES idle.
// Optional macro DEMUX_SEL_SEQ_AUTO_RR_EN replaces in_addr with an internal round-robin channel pointer.
module demux_sel_seq #(
    parameter int HOLD_CYCLES  = 4,
    parameter int GUARD_CYCLES = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_addr,
    input  logic       in_data,
    output logic [3:0] sel,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       addr_reg, addr_next;
    logic             data_reg, data_next;
    logic [3:0]       sel_reg, sel_next;
    logic             dout_reg, dout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             in_ready_reg, in_ready_next;
    logic             accept;
    logic [1:0]       channel;
    logic [3:0]       onehot_next;

    assign accept = (state_reg == IDLE) && in_valid;

`ifdef DEMUX_SEL_SEQ_AUTO_RR_EN
    logic [1:0] rr_ptr_reg;
    logic       unused_in_addr;

    assign unused_in_addr = ^in_addr;
    assign channel        = rr_ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 2'd0;
        end else if (accept) begin
            rr_ptr_reg <= rr_ptr_reg + 2'd1;
        end
    end
`else
    assign channel = in_addr;
`endif

    // Decoded from the latched address so sel can only ever be one-hot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign onehot_next[gi] = (addr_next == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    addr_next  = channel;
                    data_next  = in_data;
                    cnt_next   = HOLD_LOAD;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg == '0) begin
                    done_next = 1'b1;
                    if (GUARD_CYCLES > 0) begin
                        state_next = GUARD;
                        cnt_next   = GUARD_LOAD;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            GUARD: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Outputs are precomputed from the next state so they can be registered.
        sel_next      = (state_next == DRIVE) ? onehot_next : 4'b0000;
        dout_next     = (state_next == DRIVE) && data_next;
        busy_next     = (state_next != IDLE);
        in_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= 2'd0;
            data_reg     <= 1'b0;
            sel_reg      <= 4'b0000;
            dout_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            sel_reg      <= sel_next;
            dout_reg     <= dout_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign sel      = sel_reg;
    assign dout     = dout_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign in_ready = in_ready_reg;

endmodule

// File: doc/demux_sel_seq.md
Name: demux_sel_seq

Overview:
- Sequencer directly upstream of the 1:4 demultiplexer.
- Accepts one (channel address, data bit) request per valid/ready handshake and converts it to a registered one-hot select plus data bit.
- Holds that select for a fixed number of cycles, then inserts a guard interval with no channel selected.
- Its sel/dout outputs connect directly to the demux's one-hot select S[3:0] and data input I.

Parameters:
HOLD_CYCLES, 4, cycles sel/dout stay driven per request; legal range >= 1
GUARD_CYCLES, 1, idle cycles with sel=4'b0000 after each hold; legal range >= 0
CNT_W, 8, width of internal hold/guard counter; must satisfy 2**CNT_W > max(HOLD_CYCLES, GUARD_CYCLES)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  sequencer can accept a request
in_addr  input  2  target channel 0..3
in_data  input  1  bit to route to the target channel
sel  output  4  one-hot channel select to the demux S; 4'b0000 = no channel
dout  output  1  data bit to the demux I
busy  output  1  high in DRIVE or GUARD
done  output  1  one-cycle pulse when a hold interval completes

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: sel=4'b0000, dout=0, busy=0, done=0, in_ready=1, state=IDLE, counter=0.
- While rst_n=0 all outputs hold their reset values regardless of clk.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - in_ready=1, sel=0000, dout=0.
  - On a rising edge with in_valid=1: latch in_addr and in_data, load counter=HOLD_CYCLES-1, go to DRIVE.
- DRIVE:
  - sel=onehot(latched addr) (addr 0->0001, 1->0010, 2->0100, 3->1000), dout=latched data, in_ready=0, busy=1.
  - Counter decrements each cycle.
  - At counter=0:
    - GUARD_CYCLES>0: go to GUARD and load counter=GUARD_CYCLES-1.
    - GUARD_CYCLES=0: go directly to IDLE.
- GUARD:
  - sel=0000, dout=0, in_ready=0, busy=1.
  - Counter decrements each cycle; at 0, go to IDLE.
- Latency:
  - The request is accepted on edge N; sel/dout are valid in cycle N+1.
  - sel is non-zero for exactly HOLD_CYCLES cycles.
  - Minimum accept-to-accept spacing is 1+HOLD_CYCLES+GUARD_CYCLES cycles.
- done: asserted for exactly one cycle, the cycle immediately after the last DRIVE cycle (first GUARD cycle, or first IDLE cycle when GUARD_CYCLES=0).
- in_valid/in_addr/in_data are ignored outside IDLE. A request held valid during busy is accepted on the first IDLE edge.
- sel is never multi-hot. Any undefined state decodes to IDLE with sel=0000.
- Reset asserted mid-DRIVE or mid-GUARD: the latched request is dropped and all outputs return to reset values immediately. No done pulse is generated for the aborted request.

Optional Feature:
- Macro: DEMUX_SEL_SEQ_AUTO_RR_EN
- Defined:
  - in_addr is ignored.
  - An internal 2-bit channel pointer resets to 0 and selects the channel for each accepted request.
  - The pointer increments by 1 after each accept and wraps 3->0.
  - Pointer is cleared by rst_n.
- Undefined: the pointer logic is absent and the channel comes from in_addr as latched at accept.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with in_valid=1, in_addr=2, in_data=1 -> sel=0000, dout=0, in_ready=1, busy=0, done=0 throughout.
2. Single request, HOLD=4/GUARD=1: accept addr=2, data=1 at edge N -> sel=0100, dout=1 in cycles N+1..N+4; done=1 and sel=0000 in N+5; in_ready=1 in N+6.
3. Back-to-back, in_valid held high: addr=0/data=0, then addr=3/data=1 -> sel=0001, dout=0 for 4 cycles; 1 guard cycle of 0000; then sel=1000, dout=1. Second accept occurs exactly 6 cycles after the first.
4. Ignored input while busy: change in_addr to 1 mid-DRIVE of an addr=3 request -> sel stays 1000 for the full hold.
5. Reset mid-operation: assert rst_n=0 asynchronously during cycle 2 of DRIVE -> sel=0000 before the next edge; no done pulse; IDLE after release.
6. DEMUX_SEL_SEQ_AUTO_RR_EN defined: 5 requests with in_addr=0 -> sel sequence 0001, 0010, 0100, 1000, 0001.
